i2c_wrapper: RTL and testbench
==============================

// Module: i2c_wrapper
// PURPOSE
// - Self-contained I2C subsystem: one I2C master plus three slaves on an internal SCL/SDA bus.
// - Bus is open-drain, modelled as a wired-AND of the active-low drive enables; no tri-states.
// - Host requests one single-byte transaction per start pulse and supplies the bytes on Data.
// - Host receives read bytes on received_data.
// PARAMETERS
// - FIFO_ADDR   7'h19  7-bit address of FIFO slave
// - REG_ADDR    7'h2A  7-bit address of single-register slave
// - RF_ADDR     7'h4C  7-bit address of 4x8 register-file slave
// - FIFO_DEPTH  8      FIFO slave depth (power of 2)
// PORTS
// - clk            in   1  system clock; all logic on posedge
// - rst            in   1  asynchronous, active-low reset
// - start          in   1  one-cycle pulse: begin transaction; ignored while busy
// - Data           in   8  byte 1 = {addr[6:0], R/nW} at start; byte 2 = write data (see LOAD)
// - received_data  out  8  last byte read from a slave; reset 8'h00
// BEHAVIOUR
// - Bit period is 2 clk cycles:
//     - SCL low cycle: SDA changes.
//     - SCL high cycle: SDA sampled.
//     - SCL idles high.
// - Master FSM: IDLE -> START(2) -> ADDR(16) -> ACK1(2) -> {LOAD(2) -> WDATA(16) -> ACK2(2) | RDATA(16) -> NACK(2)} -> STOP(2) -> IDLE.
// - IDLE: SCL=SDA=1. When start=1, capture Data as the address byte, MSB first.
// - START: SDA falls while SCL is high.
// - STOP: SDA rises while SCL is high.
// - ACK1: the slave pulls SDA low if addr matches.
// - NACK in ACK1 (no slave matches): go directly to STOP; no data phase; received_data unchanged.
// - LOAD (write only): capture Data into the TX shift register on the last LOAD edge.
//     - This edge is 22 clk cycles after the edge that sampled start.
// - Write transaction length: 42 cycles. Read transaction length: 40 cycles.
// - RDATA: addressed slave drives its byte MSB first.
//     - Master samples on SCL high and shifts in.
//     - received_data updates at end of RDATA.
//     - Master then sends NACK (SDA high).
// - Slave common logic:
//     - Detect START/STOP from SDA edges while SCL is high.
//     - Shift in the address byte; ACK only on an exact 7-bit match.
//     - Release SDA outside its own ACK/read-data bits.
//     - A STOP or a new START resets slave state to idle.
// - FIFO slave:
//     - Write pushes the data byte.
//     - If full: NACK in ACK2 and drop the byte.
//     - Read pops and returns the head.
//     - If empty: return 8'hFF with no pop.
//     - Pointers wrap modulo FIFO_DEPTH; count is log2(DEPTH)+1 bits.
// - Register slave: write stores the byte; read returns it. Reset value 8'h00.
// - Register-file slave:
//     - Each access uses entry ptr[1:0], then ptr increments (wraps 3->0).
//     - Entries and ptr reset to 0.
// - Reset (async, any time): all FSMs to IDLE, SCL=SDA=1, FIFO emptied, all registers 0.
//     - A transaction in progress is abandoned.
// - start pulses while the master is not in IDLE are ignored.
// STRUCTURE
// - Package i2c_pkg:
//     - Master state enum.
//     - Slave state enum.
//     - Address constants.
//     - BIT_CYCLES=2.
// - Sub-modules:
//     - i2c_master.
//     - i2c_slave_core: shared address match / shifter / ACK logic, instantiated per slave with storage attached.
// - Wrapper contains the wired-AND bus only.
// TESTING
// - Write 8'h2F to FIFO: start, Data=8'h32, then Data=8'h2F before cycle 22.
//     - ACK1 low, ACK2 low; FIFO count=1.
// - Second write 8'hAE to FIFO -> count=2.
// - Read FIFO (Data=8'h33) -> received_data=8'h2F after 36 cycles.
// - Read again -> 8'hAE.
// - Third read -> 8'hFF.
// - Write 8'h5A to REG (8'h54), then read (8'h55) -> received_data=8'h5A.
//     - FIFO and register file unchanged.
// - Address 8'h70 (no slave) -> SDA high in ACK1, STOP at cycle 20-21; received_data unchanged.
// - Fill FIFO with 8 writes; 9th write -> NACK in ACK2.
//     - Then 8 reads return the bytes in order.
// - Assert rst low mid-WDATA -> SCL=SDA=1 immediately, FIFO empty.
//     - Next start runs normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C subsystem: master and slave state
// encodings, slave addresses, and bus timing.
package i2c_pkg;

  localparam logic [6:0]  FIFO_ADDR   = 7'h19;
  localparam logic [6:0]  REG_ADDR    = 7'h2A;
  localparam logic [6:0]  RF_ADDR     = 7'h4C;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned BIT_CYCLES  = 2;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BYTE_CYCLES = BYTE_W * BIT_CYCLES;
  localparam int unsigned CYC_W       = $clog2(BYTE_CYCLES);

  typedef enum logic [3:0] {
    M_IDLE, M_START, M_ADDR, M_ACK1, M_LOAD,
    M_WDATA, M_ACK2, M_RDATA, M_NACK, M_STOP
  } mst_state_e;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_RX, S_ACK_D, S_TX, S_WAIT
  } slv_state_e;

  typedef enum logic [1:0] {SK_FIFO, SK_REG, SK_RF} slv_kind_e;

  // Write request handed from the protocol engine to a slave's storage.
  typedef struct packed {
    logic              stb;
    logic [BYTE_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address, ACK, one data byte (write or read), STOP.
// SCL/SDA are decoded from the registered state; a 0 on sda_c pulls the bus low.
module i2c_master
  import i2c_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              sda_i,
  output logic              scl_c,
  output logic              sda_c,
  output logic [BYTE_W-1:0] rx_data
);

  mst_state_e        state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d, last_cyc;
  logic [BYTE_W-1:0] sh_q, sh_d, rdata_q, rdata_d;
  logic              rw_q, rw_d;
  logic              phase_hi, last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= M_IDLE;
      cyc_q   <= '0;
      sh_q    <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      sh_q    <= sh_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
    end
  end

  assign rx_data  = rdata_q;
  assign phase_hi = cyc_q[0];

  // Byte phases span eight bit periods; every other phase is one bit period.
  always_comb begin
    case (state_q)
      M_ADDR, M_WDATA, M_RDATA: last_cyc = CYC_W'(BYTE_CYCLES - 1);
      default:                  last_cyc = CYC_W'(BIT_CYCLES - 1);
    endcase
  end

  assign last = (cyc_q == last_cyc);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + CYC_W'(1);
    sh_d    = sh_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    scl_c   = 1'b1;
    sda_c   = 1'b1;

    case (state_q)
      M_IDLE: begin
        if (start) begin
          sh_d    = data_i;
          rw_d    = data_i[0];
          state_d = M_START;
        end
      end
      M_START: begin
        scl_c = ~cyc_q[0];
        sda_c = 1'b0;
        if (last) state_d = M_ADDR;
      end
      M_ADDR: begin
        scl_c = phase_hi;
        sda_c = sh_q[BYTE_W-1];
        if (phase_hi) sh_d = {sh_q[BYTE_W-2:0], 1'b0};
        if (last) state_d = M_ACK1;
      end
      M_ACK1: begin
        scl_c = phase_hi;
        if (last) begin
          if (sda_i)     state_d = M_STOP;
          else if (rw_q) state_d = M_RDATA;
          else           state_d = M_LOAD;
        end
      end
      M_LOAD: begin
        // SCL held low while the host byte is taken on the final LOAD edge.
        scl_c = 1'b0;
        if (last) begin
          sh_d    = data_i;
          state_d = M_WDATA;
        end
      end
      M_WDATA: begin
        scl_c = phase_hi;
        sda_c = sh_q[BYTE_W-1];
        if (phase_hi) sh_d = {sh_q[BYTE_W-2:0], 1'b0};
        if (last) state_d = M_ACK2;
      end
      M_ACK2: begin
        scl_c = phase_hi;
        if (last) state_d = M_STOP;
      end
      M_RDATA: begin
        scl_c = phase_hi;
        if (phase_hi) sh_d = {sh_q[BYTE_W-2:0], sda_i};
        if (last) begin
          rdata_d = {sh_q[BYTE_W-2:0], sda_i};
          state_d = M_NACK;
        end
      end
      M_NACK: begin
        scl_c = phase_hi;
        if (last) state_d = M_STOP;
      end
      M_STOP: begin
        scl_c = cyc_q[0];
        sda_c = 1'b0;
        if (last) state_d = M_IDLE;
      end
      default: state_d = M_IDLE;
    endcase

    if (state_d != state_q || state_q == M_IDLE) cyc_d = '0;
  end

endmodule

// File: rtl/i2c_slave_core.sv
// I2C slave protocol engine (START/STOP detect, address match, byte shifters, ACK)
// with the storage selected by KIND: FIFO, single register, or 4-entry register file.
module i2c_slave_core
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h00,
  parameter slv_kind_e  KIND = SK_REG
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_c
);

  slv_state_e        state_q, state_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [BYTE_W-1:0] sh_q, sh_d;
  logic              rw_q, rw_d;
  logic              scl_prev_q, sda_prev_q;
  wr_req_t           wr_q, wr_d;
  logic              rd_stb_q, rd_stb_d;
  logic              start_cond, stop_cond, rise;
  logic [BYTE_W-1:0] rd_byte;
  logic              wr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bcnt_q     <= '0;
      sh_q       <= '0;
      rw_q       <= 1'b0;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      wr_q       <= '0;
      rd_stb_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      scl_prev_q <= scl_i;
      sda_prev_q <= sda_i;
      wr_q       <= wr_d;
      rd_stb_q   <= rd_stb_d;
    end
  end

  assign start_cond = scl_prev_q & scl_i & sda_prev_q & ~sda_i;
  assign stop_cond  = scl_prev_q & scl_i & ~sda_prev_q & sda_i;
  assign rise       = scl_i & ~scl_prev_q;

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    sh_d     = sh_q;
    rw_d     = rw_q;
    wr_d     = '{stb: 1'b0, data: wr_q.data};
    rd_stb_d = 1'b0;
    sda_c    = 1'b1;

    case (state_q)
      S_ADDR: begin
        if (rise) begin
          sh_d   = {sh_q[BYTE_W-2:0], sda_i};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            rw_d    = sda_i;
            state_d = (sh_q[6:0] == ADDR) ? S_ACK_A : S_WAIT;
          end
        end
      end
      S_ACK_A: begin
        sda_c = 1'b0;
        if (rise) begin
          bcnt_d = '0;
          if (rw_q) begin
            sh_d     = rd_byte;
            rd_stb_d = 1'b1;
            state_d  = S_TX;
          end else begin
            state_d = S_RX;
          end
        end
      end
      S_RX: begin
        if (rise) begin
          sh_d   = {sh_q[BYTE_W-2:0], sda_i};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            // A refused byte is dropped and left un-ACKed.
            if (wr_ok) begin
              wr_d    = '{stb: 1'b1, data: {sh_q[BYTE_W-2:0], sda_i}};
              state_d = S_ACK_D;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_ACK_D: begin
        sda_c = 1'b0;
        if (rise) state_d = S_WAIT;
      end
      S_TX: begin
        sda_c = sh_q[BYTE_W-1];
        if (rise) begin
          sh_d   = {sh_q[BYTE_W-2:0], 1'b1};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = S_WAIT;
        end
      end
      default: ;
    endcase

    if (stop_cond) state_d = S_IDLE;
    if (start_cond) begin
      state_d = S_ADDR;
      bcnt_d  = '0;
    end
  end

  if (KIND == SK_FIFO) begin : g_fifo
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [BYTE_W-1:0] mem_q [FIFO_DEPTH];
    logic [BYTE_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop, empty, full;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign wr_ok   = ~full;
    assign rd_byte = empty ? 8'hFF : mem_q[rptr_q];
    assign push    = wr_q.stb & ~full;
    assign pop     = rd_stb_q & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        mem_q  <= mem_d;
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
      end
    end

    always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push) begin
        mem_d[wptr_q] = wr_q.data;
        wptr_d        = wptr_q + PTR_W'(1);
      end
      if (pop) rptr_d = rptr_q + PTR_W'(1);
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end
  end else if (KIND == SK_REG) begin : g_reg
    logic [BYTE_W-1:0] reg_q, reg_d;
    logic              unused_rd;

    assign wr_ok     = 1'b1;
    assign rd_byte   = reg_q;
    assign unused_rd = rd_stb_q;
    assign reg_d     = wr_q.stb ? wr_q.data : reg_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) reg_q <= '0;
      else        reg_q <= reg_d;
    end
  end else begin : g_rf
    logic [BYTE_W-1:0] rf_q [4];
    logic [BYTE_W-1:0] rf_d [4];
    logic [1:0]        ptr_q, ptr_d;

    assign wr_ok   = 1'b1;
    assign rd_byte = rf_q[ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) rf_q[i] <= '0;
        ptr_q <= '0;
      end else begin
        rf_q  <= rf_d;
        ptr_q <= ptr_d;
      end
    end

    // Every access, read or write, advances the entry pointer.
    always_comb begin
      rf_d  = rf_q;
      ptr_d = ptr_q;
      if (wr_q.stb) begin
        rf_d[ptr_q] = wr_q.data;
        ptr_d       = ptr_q + 2'd1;
      end else if (rd_stb_q) begin
        ptr_d = ptr_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_wrapper.sv
// I2C subsystem top: one master and three slaves joined by a wired-AND SCL/SDA bus.
module i2c_wrapper
  import i2c_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  Data,
  output logic [7:0]  received_data
);

  logic scl, sda;
  logic m_scl_c, m_sda_c, fifo_sda_c, reg_sda_c, rf_sda_c;

  // Open-drain bus: any agent driving 0 wins.
  assign scl = m_scl_c;
  assign sda = m_sda_c & fifo_sda_c & reg_sda_c & rf_sda_c;

  i2c_master u_master (
    .clk     (clk),
    .rst_n   (rst),
    .start   (start),
    .data_i  (Data),
    .sda_i   (sda),
    .scl_c   (m_scl_c),
    .sda_c   (m_sda_c),
    .rx_data (received_data)
  );

  i2c_slave_core #(.ADDR(FIFO_ADDR), .KIND(SK_FIFO)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .scl_i (scl),
    .sda_i (sda),
    .sda_c (fifo_sda_c)
  );

  i2c_slave_core #(.ADDR(REG_ADDR), .KIND(SK_REG)) u_reg (
    .clk   (clk),
    .rst_n (rst),
    .scl_i (scl),
    .sda_i (sda),
    .sda_c (reg_sda_c)
  );

  i2c_slave_core #(.ADDR(RF_ADDR), .KIND(SK_RF)) u_rf (
    .clk   (clk),
    .rst_n (rst),
    .scl_i (scl),
    .sda_i (sda),
    .sda_c (rf_sda_c)
  );

endmodule

// File: tb/tb_i2c_wrapper.sv
// Self-checking bench for i2c_wrapper: table of transactions plus hand-written
// reset, FIFO-full and busy-start sequences; read data checked via a scoreboard queue.
module tb_i2c_wrapper;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] Data = 8'h00;
  logic [7:0] received_data;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb_q[$];
  logic [7:0] fq[$];
  logic [7:0] last_rd = 8'h00;

  typedef struct {
    logic [7:0] a;
    logic [7:0] w;
    logic       ack1;
    logic       ack2;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl[17];

  i2c_wrapper dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .Data          (Data),
    .received_data (received_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  // One full transaction; samples bus/result at fixed offsets from the start edge.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] w, input logic e_ack1,
                         input logic e_ack2, input logic [7:0] e_rd, input bit poke,
                         input string nm);
    bit rd;
    int len;
    logic [7:0] exp;
    rd  = a[0];
    len = e_ack1 ? 22 : (rd ? 40 : 42);
    @(negedge clk);
    start = 1'b1;
    Data  = a;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    Data  = w;
    if (!e_ack1 && rd) sb_q.push_back(e_rd);
    for (int k = 1; k <= len; k++) begin
      @(posedge clk);
      #1;
      if (poke && k == 10) start = 1'b1;
      if (poke && k == 11) start = 1'b0;
      if (k == 19) begin
        chk({nm, " ack1_scl"}, 8'(dut.scl), 8'h01);
        chk({nm, " ack1_sda"}, 8'(dut.sda), 8'(e_ack1));
      end
      if (!e_ack1 && !rd && k == 39) chk({nm, " ack2_sda"}, 8'(dut.sda), 8'(e_ack2));
      if (!e_ack1 && rd && k == 35) chk({nm, " rd_not_yet"}, received_data, last_rd);
      if (!e_ack1 && rd && k == 36) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL %s scoreboard: got empty queue expected entry", nm);
        end else begin
          exp = sb_q.pop_front();
          chk({nm, " rdata"}, received_data, exp);
          last_rd = exp;
        end
      end
      if (k == len - 1) chk({nm, " stop_bus"}, {6'b0, dut.scl, dut.sda}, 8'h02);
      if (k == len)     chk({nm, " idle_bus"}, {6'b0, dut.scl, dut.sda}, 8'h03);
    end
    if (e_ack1) chk({nm, " rd_kept"}, received_data, last_rd);
  endtask

  initial begin
    tbl[0]  = '{8'h32, 8'h2F, 1'b0, 1'b0, 8'h00};  // write FIFO
    tbl[1]  = '{8'h32, 8'hAE, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{8'h33, 8'h00, 1'b0, 1'b0, 8'h2F};  // read FIFO
    tbl[3]  = '{8'h33, 8'h00, 1'b0, 1'b0, 8'hAE};
    tbl[4]  = '{8'h33, 8'h00, 1'b0, 1'b0, 8'hFF};  // empty
    tbl[5]  = '{8'h54, 8'h5A, 1'b0, 1'b0, 8'h00};  // write REG
    tbl[6]  = '{8'h55, 8'h00, 1'b0, 1'b0, 8'h5A};
    tbl[7]  = '{8'h33, 8'h00, 1'b0, 1'b0, 8'hFF};
    tbl[8]  = '{8'h99, 8'h00, 1'b0, 1'b0, 8'h00};  // RF entry 0
    tbl[9]  = '{8'h98, 8'h11, 1'b0, 1'b0, 8'h00};  // RF entry 1
    tbl[10] = '{8'h98, 8'h22, 1'b0, 1'b0, 8'h00};  // RF entry 2
    tbl[11] = '{8'h98, 8'h33, 1'b0, 1'b0, 8'h00};  // RF entry 3
    tbl[12] = '{8'h99, 8'h00, 1'b0, 1'b0, 8'h00};  // wrapped to entry 0
    tbl[13] = '{8'h99, 8'h00, 1'b0, 1'b0, 8'h11};
    tbl[14] = '{8'h70, 8'h55, 1'b1, 1'b0, 8'h00};  // no slave
    tbl[15] = '{8'hE1, 8'h00, 1'b1, 1'b0, 8'h00};  // no slave, read
    tbl[16] = '{8'h55, 8'h00, 1'b0, 1'b0, 8'h5A};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", received_data, 8'h00);
    chk("reset_bus", {6'b0, dut.scl, dut.sda}, 8'h03);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++)
      run_txn(tbl[i].a, tbl[i].w, tbl[i].ack1, tbl[i].ack2, tbl[i].rd, 1'b0,
              $sformatf("vec%0d", i));

    // Reset in the middle of a write data phase.
    run_txn(8'h32, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, "pre_rst_wr");
    @(negedge clk);
    start = 1'b1;
    Data  = 8'h32;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    Data  = 8'h02;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_bus", {6'b0, dut.scl, dut.sda}, 8'h03);
    chk("rst_rdata", received_data, 8'h00);
    last_rd = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    run_txn(8'h33, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, "post_rst_fifo");
    run_txn(8'h55, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "post_rst_reg");
    run_txn(8'h54, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, "reg_wr3c");
    run_txn(8'h55, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, "reg_rd3c");

    // Fill the FIFO, overflow once, then drain in order.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'(8'h10 + 8'(i * 7));
      fq.push_back(v);
      run_txn(8'h32, v, 1'b0, 1'b0, 8'h00, 1'b0, $sformatf("fill%0d", i));
    end
    run_txn(8'h32, 8'hEE, 1'b0, 1'b1, 8'h00, 1'b0, "overflow");
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = fq.pop_front();
      run_txn(8'h33, 8'h00, 1'b0, 1'b0, e, 1'b0, $sformatf("drain%0d", i));
    end
    run_txn(8'h33, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, "drained");

    // Start pulse while busy must not disturb or restart the transaction.
    run_txn(8'h54, 8'h66, 1'b0, 1'b0, 8'h00, 1'b1, "busy_start");
    repeat (3) @(posedge clk);
    #1;
    chk("busy_idle", {6'b0, dut.scl, dut.sda}, 8'h03);
    run_txn(8'h55, 8'h00, 1'b0, 1'b0, 8'h66, 1'b0, "busy_rd");

    chk("sb_empty", 8'(sb_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
